// File: rtl/hub_pkg.sv
// Shared definitions for hub memory initiators: transfer size codes,
// requester FSM encoding and the start of the read-only region.
package hub_pkg;

  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_WORD = 2'b01;
  localparam logic [1:0]  SZ_LONG = 2'b10;  // 2'b11 is also handled as a long

  localparam logic [15:0] HUB_ROM_BASE = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_CAPT = 2'b10
  } hub_state_e;

endpackage

// File: rtl/hub_lane_align.sv
// Byte-lane steering for hub accesses: builds write strobes and replicated
// write data from a right-justified value, and extracts the addressed
// byte/halfword/long from a memory word, zero-extended. Purely combinational.
module hub_lane_align
  import hub_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  input  logic [31:0] q,
  output logic [3:0]  wb,
  output logic [31:0] d,
  output logic [31:0] rd
);

  // Lane selection by transfer size; anything not byte/word is a long
  always_comb begin
    wb = 4'b1111;
    d  = data;
    rd = q;
    case (size)
      SZ_BYTE: begin
        wb = 4'b0001 << addr_lo;
        d  = {4{data[7:0]}};
        case (addr_lo)
          2'd0:    rd = {24'h0, q[7:0]};
          2'd1:    rd = {24'h0, q[15:8]};
          2'd2:    rd = {24'h0, q[23:16]};
          default: rd = {24'h0, q[31:24]};
        endcase
      end
      SZ_WORD: begin
        // addr_lo[0] is ignored: halfwords are always lane-pair aligned
        wb = addr_lo[1] ? 4'b1100 : 4'b0011;
        d  = {2{data[15:0]}};
        rd = addr_lo[1] ? {16'h0, q[31:16]} : {16'h0, q[15:0]};
      end
      default: begin
        wb = 4'b1111;
        d  = data;
        rd = q;
      end
    endcase
  end

endmodule

// File: rtl/hub_requester.sv
// Cog-side hub memory initiator. Holds one request until this cog's slot
// strobe, drives the memory bus during the waiting state, and captures the
// aligned read data the cycle after the slot. Bus outputs come only from
// registers and the state, so nothing combinational reaches them from inputs.
module hub_requester
  import hub_pkg::*;
(
  input  logic        clk_cog,
  input  logic        nres,
  input  logic        ena_bus,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        mem_w,
  output logic [3:0]  mem_wb,
  output logic [13:0] mem_a,
  output logic [31:0] mem_d,
  input  logic [31:0] mem_q
);

  hub_state_e  state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic [15:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  lane_wb;
  logic [31:0] lane_d;
  logic [31:0] lane_rd;

  hub_lane_align u_lane (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .data    (data_q),
    .q       (mem_q),
    .wb      (lane_wb),
    .d       (lane_d),
    .rd      (lane_rd)
  );

  // Address and data follow the latched request, so they hold between accesses
  assign mem_a = addr_q[15:2];
  assign mem_d = lane_d;

  // State register; reset abandons any request in flight
  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and state-decoded bus controls (strobes live only in WAIT)
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_w     = 1'b0;
    mem_wb    = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        mem_w  = we_q;
        mem_wb = lane_wb;
        if (ena_bus) state_d = ST_CAPT;
      end
      ST_CAPT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, loaded only on acceptance
  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      we_q   <= 1'b0;
      size_q <= SZ_BYTE;
      addr_q <= 16'h0000;
      data_q <= 32'h0;
    end else if (req_ready && req_valid) begin
      we_q   <= req_we;
      size_q <= req_size;
      addr_q <= req_addr;
      data_q <= req_data;
    end
  end

  // Response capture: memory data is valid in CAPT; rsp_data holds until the next one
  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      if (state_q == ST_CAPT) begin
        rsp_valid <= 1'b1;
        rsp_data  <= lane_rd;
      end
    end
  end

endmodule

// File: tb/tb_hub_requester.sv
// Bench for hub_requester with a behavioural hub memory that reads before it
// writes on the slot cycle and ignores writes at or above the ROM base.
module tb_hub_requester;
  import hub_pkg::*;

  logic        clk_cog = 1'b0;
  logic        nres = 1'b0;
  logic        ena_bus = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [15:0] req_addr = 16'h0;
  logic [31:0] req_data = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        mem_w;
  logic [3:0]  mem_wb;
  logic [13:0] mem_a;
  logic [31:0] mem_d;
  logic [31:0] mem_q = 32'h0;

  int checks = 0;
  int failures = 0;

  hub_requester dut (
    .clk_cog   (clk_cog),
    .nres      (nres),
    .ena_bus   (ena_bus),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mem_w     (mem_w),
    .mem_wb    (mem_wb),
    .mem_a     (mem_a),
    .mem_d     (mem_d),
    .mem_q     (mem_q)
  );

  always #5 clk_cog = ~clk_cog;

  logic [31:0] mem [0:16383];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nd[8*b +: 8];
    return r;
  endfunction

  // Hub memory: on the slot edge return old contents, then write RAM only
  always @(posedge clk_cog) begin
    if (ena_bus) begin
      mem_q <= mem[mem_a];
      if (mem_w && ({mem_a, 2'b00} < HUB_ROM_BASE))
        mem[mem_a] <= merge(mem[mem_a], mem_d, mem_wb);
    end
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [31:0] data;
    int          gap;     // WAIT cycles before the slot cycle
    logic [3:0]  exp_wb;
    logic [13:0] exp_a;
    logic [31:0] exp_d;
    logic [31:0] exp_rsp;
  } vec_t;

  vec_t vecs[10];

  // One request: accept, wait gap cycles, slot, capture, response
  task automatic run_txn(input int idx, input vec_t v);
    int bad;
    bad = 0;
    chk("ready_idle", idx, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_we    = v.we;
    req_size  = v.size;
    req_addr  = v.addr;
    req_data  = v.data;
    @(posedge clk_cog); #1;
    req_valid = 1'b0;
    req_data  = 32'hFFFF_FFFF;
    for (int k = 0; k < v.gap; k++) begin
      if (mem_w !== v.we || mem_wb !== v.exp_wb || req_ready !== 1'b0 || rsp_valid !== 1'b0)
        bad++;
      @(posedge clk_cog); #1;
    end
    ena_bus = 1'b1;
    chk("mem_wb", idx, {28'h0, mem_wb}, {28'h0, v.exp_wb});
    chk("mem_a", idx, {18'h0, mem_a}, {18'h0, v.exp_a});
    chk("mem_d", idx, mem_d, v.exp_d);
    chk("mem_w", idx, {31'h0, mem_w}, {31'h0, v.we});
    @(posedge clk_cog); #1;
    ena_bus = 1'b0;
    if (mem_w !== 1'b0 || mem_wb !== 4'b0000 || rsp_valid !== 1'b0 || req_ready !== 1'b0)
      bad++;
    @(posedge clk_cog); #1;
    chk("rsp_valid", idx, {31'h0, rsp_valid}, 32'h1);
    chk("rsp_data", idx, rsp_data, v.exp_rsp);
    if (mem_w !== 1'b0 || mem_wb !== 4'b0000 || req_ready !== 1'b1) bad++;
    @(posedge clk_cog); #1;
    chk("rsp_pulse", idx, {31'h0, rsp_valid}, 32'h0);
    chk("rsp_hold", idx, rsp_data, v.exp_rsp);
    chk("wait_ctrl", idx, bad, 0);
  endtask

  initial begin
    int bad;

    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[14'h048D] = 32'h1122_3344;
    mem[14'h0800] = 32'h7788_9900;
    mem[14'h3000] = 32'h8765_4321;

    //            we    size     addr      data          gap wb       a         d              rsp
    vecs[0] = '{1'b1, SZ_LONG, 16'h1234, 32'hDEADBEEF, 4, 4'b1111, 14'h048D, 32'hDEADBEEF, 32'h11223344};
    vecs[1] = '{1'b1, SZ_BYTE, 16'h1235, 32'hFFFFFF5A, 0, 4'b0010, 14'h048D, 32'h5A5A5A5A, 32'h000000BE};
    vecs[2] = '{1'b0, SZ_LONG, 16'h1234, 32'h00000000, 1, 4'b1111, 14'h048D, 32'h00000000, 32'hDEAD5AEF};
    vecs[3] = '{1'b0, SZ_WORD, 16'h1236, 32'h00000000, 2, 4'b1100, 14'h048D, 32'h00000000, 32'h0000DEAD};
    vecs[4] = '{1'b0, SZ_BYTE, 16'h1237, 32'h00000000, 0, 4'b1000, 14'h048D, 32'h00000000, 32'h000000DE};
    vecs[5] = '{1'b1, SZ_LONG, 16'hC000, 32'hCAFEF00D, 3, 4'b1111, 14'h3000, 32'hCAFEF00D, 32'h87654321};
    vecs[6] = '{1'b0, SZ_LONG, 16'hC000, 32'h00000000, 0, 4'b1111, 14'h3000, 32'h00000000, 32'h87654321};
    vecs[7] = '{1'b1, SZ_WORD, 16'h2003, 32'h0000A55A, 1, 4'b1100, 14'h0800, 32'hA55AA55A, 32'h00007788};
    vecs[8] = '{1'b0, SZ_BYTE, 16'h2001, 32'h00000000, 0, 4'b0010, 14'h0800, 32'h00000000, 32'h00000099};
    vecs[9] = '{1'b0, 2'b11,   16'h2002, 32'h12345678, 2, 4'b1111, 14'h0800, 32'h12345678, 32'hA55A9900};

    // Reset values
    repeat (3) @(posedge clk_cog);
    #1;
    chk("rst_ready", 0, {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", 0, {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_data", 0, rsp_data, 32'h0);
    chk("rst_mem_w", 0, {31'h0, mem_w}, 32'h0);
    chk("rst_mem_wb", 0, {28'h0, mem_wb}, 32'h0);
    chk("rst_mem_a", 0, {18'h0, mem_a}, 32'h0);
    chk("rst_mem_d", 0, mem_d, 32'h0);
    nres = 1'b1;
    @(posedge clk_cog); #1;

    for (int i = 0; i < 10; i++) run_txn(i, vecs[i]);

    // Slot strobe in the acceptance cycle is ignored; the access waits for the next one
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = SZ_LONG;
    req_addr  = 16'h1234;
    req_data  = 32'h0;
    ena_bus   = 1'b1;
    @(posedge clk_cog); #1;
    req_valid = 1'b0;
    ena_bus   = 1'b0;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) bad++;
      @(posedge clk_cog); #1;
    end
    chk("early_ena_wait", 0, bad, 0);
    chk("early_ena_a", 0, {18'h0, mem_a}, 32'h048D);
    ena_bus = 1'b1;
    @(posedge clk_cog); #1;
    ena_bus = 1'b0;
    chk("early_ena_capt", 0, {31'h0, rsp_valid}, 32'h0);
    @(posedge clk_cog); #1;
    chk("early_ena_rsp_valid", 0, {31'h0, rsp_valid}, 32'h1);
    chk("early_ena_rsp_data", 0, rsp_data, 32'hDEAD5AEF);
    @(posedge clk_cog); #1;
    chk("early_ena_pulse", 0, {31'h0, rsp_valid}, 32'h0);

    // Reset while waiting for the slot drops the request
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = SZ_LONG;
    req_addr  = 16'h1234;
    req_data  = 32'h0BAD_0BAD;
    @(posedge clk_cog); #1;
    req_valid = 1'b0;
    chk("wait_before_rst", 0, {31'h0, mem_w}, 32'h1);
    #2;
    nres = 1'b0;
    #1;
    chk("arst_ready", 0, {31'h0, req_ready}, 32'h1);
    chk("arst_mem_w", 0, {31'h0, mem_w}, 32'h0);
    chk("arst_mem_wb", 0, {28'h0, mem_wb}, 32'h0);
    chk("arst_mem_a", 0, {18'h0, mem_a}, 32'h0);
    chk("arst_mem_d", 0, mem_d, 32'h0);
    chk("arst_rsp_data", 0, rsp_data, 32'h0);
    chk("arst_rsp_valid", 0, {31'h0, rsp_valid}, 32'h0);
    @(posedge clk_cog); #3;
    nres = 1'b1;
    @(posedge clk_cog); #1;
    ena_bus = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_w !== 1'b0) bad++;
      @(posedge clk_cog); #1;
      ena_bus = 1'b0;
    end
    chk("post_rst_idle", 0, bad, 0);

    // The dropped write must not have reached memory
    run_txn(10, '{1'b0, SZ_LONG, 16'h1234, 32'h0, 0, 4'b1111, 14'h048D, 32'h0, 32'hDEAD5AEF});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
